// File: rtl/io_remap_unit_pkg.sv
// ============================================================================
// Module : gb_remap_pkg
// Brief  : Shared types and the data transform for the FFxx I/O remapper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package gb_remap_pkg;

  localparam int MODES  = 4;
  localparam int MODE_W = $clog2(MODES);

  localparam logic [MODE_W-1:0] MODE_DMG      = MODE_W'(0);
  localparam logic [MODE_W-1:0] MODE_MEGADUCK = MODE_W'(1);

  typedef enum logic [1:0] {
    XF_NONE    = 2'd0,
    XF_NIBSWAP = 2'd1,
    XF_VOLSWZ  = 2'd2,
    XF_RSVD    = 2'd3
  } xform_t;

  typedef struct packed {
    logic             valid;
    logic [MODES-1:0] mode_mask;
    logic [7:0]       src_lo;
    logic [7:0]       dst_lo;
    xform_t           xform;
  } remap_entry_t;

  // Every transform is its own inverse, so reads and writes share this function.
  function automatic logic [7:0] apply_xform(xform_t xf, logic [7:0] d);
    logic [7:0] r;
    r = d;
    case (xf)
      XF_NIBSWAP: r = {d[3:0], d[7:4]};
      XF_VOLSWZ:  r = {d[7], d[6] ^ d[5], d[5:0]};
      default:    r = d;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/io_remap_unit_if.sv
// ============================================================================
// Module : io_remap_if
// Brief  : CPU request, remapped output and table configuration signals.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface io_remap_if #(
  parameter int IDX_W  = 5,
  parameter int DATA_W = 8
);
  import gb_remap_pkg::*;

  logic [MODE_W-1:0] mode_sel;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  remap_entry_t      cfg_entry;
  logic              cfg_clear;
  logic              cfg_busy;
  logic              cfg_err;
  logic              req_valid;
  logic [15:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              out_valid;
  logic [15:0]       out_addr;
  logic [DATA_W-1:0] out_wdata;
  logic              out_hit;
  logic [DATA_W-1:0] rd_in;
  logic [DATA_W-1:0] rd_out;

  modport master (
    output mode_sel, cfg_we, cfg_idx, cfg_entry, cfg_clear,
    output req_valid, req_addr, req_wdata, rd_in,
    input  cfg_busy, cfg_err, out_valid, out_addr, out_wdata, out_hit, rd_out
  );

  modport slave (
    input  mode_sel, cfg_we, cfg_idx, cfg_entry, cfg_clear,
    input  req_valid, req_addr, req_wdata, rd_in,
    output cfg_busy, cfg_err, out_valid, out_addr, out_wdata, out_hit, rd_out
  );

endinterface

`default_nettype wire

// File: rtl/io_remap_unit_match.sv
// ============================================================================
// Module : io_remap_match
// Brief  : Parallel FFxx compare across all entries, lowest index wins.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module io_remap_match
  import gb_remap_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] ent_valid,
  input  logic [MODES-1:0]   ent_mask [ENTRIES],
  input  logic [7:0]         ent_src  [ENTRIES],
  input  logic [15:0]        addr,
  input  logic [MODE_W-1:0]  mode_sel,
  input  logic               enable,
  output logic               hit,
  output logic [IDX_W-1:0]   idx
);

  logic [ENTRIES-1:0] match;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
    assign match[g] = enable && ent_valid[g] && (addr[15:8] == 8'hFF) &&
                      (ent_src[g] == addr[7:0]) && ent_mask[g][mode_sel];
  end

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/io_remap_unit.sv
// ============================================================================
// Module : io_remap_unit
// Brief  : Table-driven FFxx register remapper with clear FSM and 1-cycle lookup.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module io_remap_unit
  import gb_remap_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int DATA_W  = 8,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic     clk_sys,
  input  logic     reset,
  io_remap_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              clr_en;
  logic              wr_ok;
  logic              err_q;

  remap_entry_t      table_q [ENTRIES];
  logic [ENTRIES-1:0] ent_valid;
  logic [MODES-1:0]  ent_mask [ENTRIES];
  logic [7:0]        ent_src  [ENTRIES];
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  remap_entry_t      sel;

  logic              out_valid_q;
  logic [15:0]       out_addr_q;
  logic [DATA_W-1:0] out_wdata_q;
  logic              out_hit_q;
  xform_t            xf_q;

  // A write is dropped while clearing, when a clear starts, or when out of range.
  assign wr_ok = bus.cfg_we && (state_q == ST_IDLE) && !bus.cfg_clear &&
                 (int'(bus.cfg_idx) < ENTRIES);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= bus.cfg_we && !wr_ok;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (clr_en && (cnt_q == IDX_W'(i))) begin
          table_q[i].valid <= 1'b0;
        end else if (wr_ok && (bus.cfg_idx == IDX_W'(i))) begin
          table_q[i] <= bus.cfg_entry;
        end
      end
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_fields
    assign ent_valid[g] = table_q[g].valid;
    assign ent_mask[g]  = table_q[g].mode_mask;
    assign ent_src[g]   = table_q[g].src_lo;
  end

  io_remap_match #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_match (
    .ent_valid (ent_valid),
    .ent_mask  (ent_mask),
    .ent_src   (ent_src),
    .addr      (bus.req_addr),
    .mode_sel  (bus.mode_sel),
    .enable    (state_q == ST_IDLE),
    .hit       (hit),
    .idx       (hit_idx)
  );

  assign sel = table_q[hit_idx];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= 16'h0000;
      out_wdata_q <= '0;
      out_hit_q   <= 1'b0;
      xf_q        <= XF_NONE;
    end else begin
      out_valid_q <= bus.req_valid;
      out_hit_q   <= hit;
      if (hit) begin
        out_addr_q  <= {8'hFF, sel.dst_lo};
        out_wdata_q <= apply_xform(sel.xform, bus.req_wdata);
        xf_q        <= sel.xform;
      end else begin
        out_addr_q  <= bus.req_addr;
        out_wdata_q <= bus.req_wdata;
        xf_q        <= XF_NONE;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_wdata = out_wdata_q;
  assign bus.out_hit   = out_hit_q;
  assign bus.rd_out    = apply_xform(xf_q, bus.rd_in);
  assign bus.cfg_busy  = (state_q == ST_CLEAR);
  assign bus.cfg_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_io_remap_unit.sv
// ============================================================================
// Module : tb_io_remap_unit
// Brief  : Directed vector table plus clear/reset sequences for io_remap_unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_io_remap_unit;
  import gb_remap_pkg::*;

  localparam int ENTRIES = 32;
  localparam int IDX_W   = 5;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  io_remap_if #(.IDX_W(IDX_W), .DATA_W(8)) bus ();

  io_remap_unit #(.ENTRIES(ENTRIES), .DATA_W(8)) dut (
    .clk_sys (clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rd_in;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata;
    logic        exp_hit;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic remap_entry_t mk(logic [7:0] src, logic [7:0] dst, xform_t xf);
    remap_entry_t e;
    e.valid     = 1'b1;
    e.mode_mask = 4'b0010;
    e.src_lo    = src;
    e.dst_lo    = dst;
    e.xform     = xf;
    return e;
  endfunction

  task automatic load(input int idx, input remap_entry_t e);
    bus.cfg_we    = 1'b1;
    bus.cfg_idx   = IDX_W'(idx);
    bus.cfg_entry = e;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic access(input logic [1:0] mode, input logic [15:0] addr, input logic [7:0] wd);
    bus.req_valid = 1'b1;
    bus.mode_sel  = mode;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    tick();
  endtask

  initial begin
    int busy_cnt;
    int err_cnt;
    int hit_cnt;

    vecs[0] = '{2'd1, 16'hFF10, 8'h91, 8'h00, 16'hFF40, 8'h91, 1'b1, 8'h00};
    vecs[1] = '{2'd0, 16'hFF10, 8'h91, 8'h00, 16'hFF10, 8'h91, 1'b0, 8'h00};
    vecs[2] = '{2'd1, 16'hFF21, 8'hA5, 8'h3C, 16'hFF12, 8'h5A, 1'b1, 8'hC3};
    vecs[3] = '{2'd1, 16'hFF2C, 8'h20, 8'h00, 16'hFF1C, 8'h60, 1'b1, 8'h00};
    vecs[4] = '{2'd1, 16'hFF2C, 8'h60, 8'h60, 16'hFF1C, 8'h20, 1'b1, 8'h20};
    vecs[5] = '{2'd1, 16'hFF41, 8'hA5, 8'h3C, 16'hFF50, 8'hA5, 1'b1, 8'h3C};
    vecs[6] = '{2'd1, 16'hFE41, 8'hA5, 8'h3C, 16'hFE41, 8'hA5, 1'b0, 8'h3C};
    vecs[7] = '{2'd2, 16'hFF21, 8'hA5, 8'h3C, 16'hFF21, 8'hA5, 1'b0, 8'h3C};
    vecs[8] = '{2'd1, 16'hFF99, 8'h12, 8'h34, 16'hFF99, 8'h12, 1'b0, 8'h34};

    reset         = 1'b1;
    bus.mode_sel  = MODE_DMG;
    bus.cfg_we    = 1'b0;
    bus.cfg_idx   = '0;
    bus.cfg_entry = '0;
    bus.cfg_clear = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = 16'h0000;
    bus.req_wdata = 8'h00;
    bus.rd_in     = 8'h00;
    tick();
    tick();
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_hit",   32'(bus.out_hit),   32'd0);
    chk("reset out_addr",  32'(bus.out_addr),  32'h0000);
    chk("reset out_wdata", 32'(bus.out_wdata), 32'h00);
    chk("reset cfg_busy",  32'(bus.cfg_busy),  32'd0);
    chk("reset cfg_err",   32'(bus.cfg_err),   32'd0);
    reset = 1'b0;
    tick();

    access(2'd1, 16'hFF40, 8'h91);
    chk("empty out_valid", 32'(bus.out_valid), 32'd1);
    chk("empty out_addr",  32'(bus.out_addr),  32'hFF40);
    chk("empty out_wdata", 32'(bus.out_wdata), 32'h91);
    chk("empty out_hit",   32'(bus.out_hit),   32'd0);
    bus.req_valid = 1'b0;

    load(0, mk(8'h10, 8'h40, XF_NONE));
    load(1, mk(8'h21, 8'h12, XF_NIBSWAP));
    load(2, mk(8'h2C, 8'h1C, XF_VOLSWZ));
    load(3, mk(8'h41, 8'h50, XF_NONE));
    load(7, mk(8'h41, 8'h77, XF_NIBSWAP));

    for (int i = 0; i < 9; i++) begin
      access(vecs[i].mode, vecs[i].addr, vecs[i].wdata);
      bus.rd_in = vecs[i].rd_in;
      #1;
      chk($sformatf("vec%0d out_addr", i),  32'(bus.out_addr),  32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d out_wdata", i), 32'(bus.out_wdata), 32'(vecs[i].exp_wdata));
      chk($sformatf("vec%0d out_hit", i),   32'(bus.out_hit),   32'(vecs[i].exp_hit));
      chk($sformatf("vec%0d rd_out", i),    32'(bus.rd_out),    32'(vecs[i].exp_rd));
    end

    // Write and matching request in the same cycle: the request sees the old entry.
    bus.cfg_we    = 1'b1;
    bus.cfg_idx   = IDX_W'(5);
    bus.cfg_entry = mk(8'h33, 8'h66, XF_NONE);
    access(2'd1, 16'hFF33, 8'h0F);
    bus.cfg_we    = 1'b0;
    chk("samecyc out_hit",  32'(bus.out_hit),  32'd0);
    chk("samecyc out_addr", 32'(bus.out_addr), 32'hFF33);
    access(2'd1, 16'hFF33, 8'h0F);
    chk("nextcyc out_hit",  32'(bus.out_hit),  32'd1);
    chk("nextcyc out_addr", 32'(bus.out_addr), 32'hFF66);

    // Clear together with a write: clear wins, write rejected.
    bus.req_valid = 1'b0;
    bus.cfg_clear = 1'b1;
    bus.cfg_we    = 1'b1;
    bus.cfg_idx   = IDX_W'(8);
    bus.cfg_entry = mk(8'h88, 8'h99, XF_NONE);
    tick();
    bus.cfg_clear = 1'b0;
    bus.cfg_we    = 1'b0;
    chk("clear+we cfg_err", 32'(bus.cfg_err),  32'd1);
    chk("clear start busy", 32'(bus.cfg_busy), 32'd1);
    busy_cnt = 1;
    err_cnt  = 0;
    hit_cnt  = 0;
    bus.req_valid = 1'b1;
    bus.mode_sel  = 2'd1;
    bus.req_addr  = 16'hFF10;
    for (int c = 0; c < 100 && bus.cfg_busy; c++) begin
      bus.cfg_we    = (c == 5);
      bus.cfg_idx   = IDX_W'(4);
      bus.cfg_clear = (c == 10);
      tick();
      bus.cfg_we    = 1'b0;
      bus.cfg_clear = 1'b0;
      if (bus.cfg_busy) busy_cnt++;
      if (bus.cfg_err)  err_cnt++;
      if (bus.out_hit)  hit_cnt++;
    end
    chk("clear busy cycles", 32'(busy_cnt), 32'(ENTRIES));
    chk("clear mid-we err pulses", 32'(err_cnt), 32'd1);
    chk("clear lookups hit", 32'(hit_cnt), 32'd0);
    access(2'd1, 16'hFF10, 8'h44);
    chk("after clear out_hit",  32'(bus.out_hit),  32'd0);
    chk("after clear out_addr", 32'(bus.out_addr), 32'hFF10);

    // Reset in the middle of a clear, with an entry the counter has not yet reached.
    bus.req_valid = 1'b0;
    load(30, mk(8'h10, 8'h40, XF_NONE));
    access(2'd1, 16'hFF10, 8'h44);
    chk("reload out_hit", 32'(bus.out_hit), 32'd1);
    bus.req_valid = 1'b0;
    bus.cfg_clear = 1'b1;
    tick();
    bus.cfg_clear = 1'b0;
    repeat (4) tick();
    chk("pre-reset busy", 32'(bus.cfg_busy), 32'd1);
    reset = 1'b1;
    #2;
    chk("mid-clear reset busy", 32'(bus.cfg_busy), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    access(2'd1, 16'hFF10, 8'h44);
    chk("post-reset out_hit",  32'(bus.out_hit),  32'd0);
    chk("post-reset out_addr", 32'(bus.out_addr), 32'hFF10);
    chk("post-reset busy",     32'(bus.cfg_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
